// File: rtl/axi_arbiter_w.sv
// Round-robin AW/W/B arbiter for four AXI masters sharing one slave write port.
// Define AXI_ARB_W_LEN_CHECK_EN to add the sticky burst-length checker (len_err).
module axi_arbiter_w #(
   parameter int RESET_LAST = 3,
   parameter int LEN_W      = 8
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   input  logic             m0_AWVALID,
   input  logic             m1_AWVALID,
   input  logic             m2_AWVALID,
   input  logic             m3_AWVALID,
   input  logic             s_AWVALID,
   input  logic             s_AWREADY,
   input  logic [LEN_W-1:0] s_AWLEN,
   input  logic             s_WVALID,
   input  logic             s_WREADY,
   input  logic             s_WLAST,
   input  logic             s_BVALID,
   input  logic             s_BREADY,
   output logic             m0_wgrnt,
   output logic             m1_wgrnt,
   output logic             m2_wgrnt,
   output logic             m3_wgrnt,
   output logic             w_en,
   output logic             b_en,
   output logic             busy,
   output logic             len_err
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t     state, state_nxt;
   logic [3:0] grant, grant_nxt;
   logic [1:0] last, last_nxt;
   logic [3:0] req;
   logic       aw_hs, w_hs, b_hs;

   assign req   = {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID};
   assign aw_hs = s_AWVALID & s_AWREADY;
   assign w_hs  = s_WVALID & s_WREADY;
   assign b_hs  = s_BVALID & s_BREADY;

   // Walk from lowest to highest priority so the nearest requester after prev wins.
   function automatic logic [3:0] rr_pick(input logic [1:0] prev, input logic [3:0] r);
      logic [3:0] pick;
      logic [1:0] idx;
      pick = 4'b0000;
      for (int k = 4; k >= 1; k--) begin
         idx = prev + 2'(k);
         if (r[idx]) pick = 4'b0001 << idx;
      end
      return pick;
   endfunction

   function automatic logic [1:0] grant_idx(input logic [3:0] g);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (g[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state <= IDLE;
         grant <= 4'b0000;
         last  <= 2'(RESET_LAST);
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         last  <= last_nxt;
      end
   end

   // The grant only changes when leaving IDLE or RESP, so bursts never interleave.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (|req) begin
               grant_nxt = rr_pick(last, req);
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            if (aw_hs) state_nxt = DATA;
         end
         DATA: begin
            if (w_hs && s_WLAST) state_nxt = RESP;
         end
         RESP: begin
            if (b_hs) begin
               last_nxt  = grant_idx(grant);
               grant_nxt = rr_pick(grant_idx(grant), req);
               state_nxt = (|req) ? ADDR : IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = 4'b0000;
         end
      endcase
   end

   always_comb begin
      w_en = (state == DATA);
      b_en = (state == RESP);
      busy = |grant;
      {m3_wgrnt, m2_wgrnt, m1_wgrnt, m0_wgrnt} = grant;
   end

`ifdef AXI_ARB_W_LEN_CHECK_EN
   logic [LEN_W-1:0] len_q;
   logic [LEN_W:0]   beat_cnt;
   logic             len_err_q;

   // A beat is wrong when WLAST disagrees with "this is beat number AWLEN".
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         len_q     <= '0;
         beat_cnt  <= '0;
         len_err_q <= 1'b0;
      end else begin
         if (state == ADDR && aw_hs) begin
            len_q    <= s_AWLEN;
            beat_cnt <= '0;
         end else if (state == DATA && w_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (s_WLAST != (beat_cnt == {1'b0, len_q})) len_err_q <= 1'b1;
         end
      end
   end

   assign len_err = len_err_q;
`else
   logic len_unused;
   assign len_unused = ^s_AWLEN;
   assign len_err    = 1'b0;
`endif

endmodule

// File: tb/tb_axi_arbiter_w.sv
// Randomized bench for axi_arbiter_w: a transaction-level owner/phase model predicts
// grants and enables every cycle, plus directed grant-order and reset scenarios.
module tb_axi_arbiter_w;

   localparam int LEN_W = 8;

   logic             ACLK = 1'b0;
   logic             ARESETn;
   logic             m0_AWVALID, m1_AWVALID, m2_AWVALID, m3_AWVALID;
   logic             s_AWVALID, s_AWREADY;
   logic [LEN_W-1:0] s_AWLEN;
   logic             s_WVALID, s_WREADY, s_WLAST;
   logic             s_BVALID, s_BREADY;
   logic             m0_wgrnt, m1_wgrnt, m2_wgrnt, m3_wgrnt;
   logic             w_en, b_en, busy, len_err;

   axi_arbiter_w #(.RESET_LAST(3), .LEN_W(LEN_W)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .m0_AWVALID(m0_AWVALID), .m1_AWVALID(m1_AWVALID),
      .m2_AWVALID(m2_AWVALID), .m3_AWVALID(m3_AWVALID),
      .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY), .s_AWLEN(s_AWLEN),
      .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WLAST(s_WLAST),
      .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
      .m0_wgrnt(m0_wgrnt), .m1_wgrnt(m1_wgrnt), .m2_wgrnt(m2_wgrnt), .m3_wgrnt(m3_wgrnt),
      .w_en(w_en), .b_en(b_en), .busy(busy), .len_err(len_err)
   );

   always #5 ACLK = ~ACLK;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: who owns the slave (-1 = nobody) and which phase (0 idle,1 addr,2 data,3 resp).
   int       m_owner, m_phase, m_last, m_len, m_cnt;
   bit       m_err;
   bit [3:0] pending;
   bit       hold_all;
   int       req_pct, aw_pct, w_pct, b_pct, fixed_len, bad_pct, force_target, target_last;
   int       order_q[$];
   logic [3:0] prev_g;

   function automatic int pick(input int last, input bit [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         if (r[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   function automatic int ohIdx(input logic [3:0] g);
      for (int i = 0; i < 4; i++) begin
         if (g[i]) return i;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic zeroInputs();
      {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID} = 4'b0000;
      s_AWVALID = 1'b0; s_AWREADY = 1'b0; s_AWLEN = '0;
      s_WVALID = 1'b0; s_WREADY = 1'b0; s_WLAST = 1'b0;
      s_BVALID = 1'b0; s_BREADY = 1'b0;
   endtask

   // Drops reset wherever the caller is in time and checks outputs clear without a clock edge.
   task automatic resetDut();
      ARESETn = 1'b0;
      zeroInputs();
      #1;
      checkOutput("rst_grant", 32'({m3_wgrnt, m2_wgrnt, m1_wgrnt, m0_wgrnt}), 32'h0);
      checkOutput("rst_w_en", 32'(w_en), 32'h0);
      checkOutput("rst_b_en", 32'(b_en), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_len_err", 32'(len_err), 32'h0);
      m_owner = -1; m_phase = 0; m_last = 3; m_len = 0; m_cnt = 0; m_err = 1'b0;
      pending = 4'b0000; hold_all = 1'b0; prev_g = 4'b0000;
      order_q.delete();
      repeat (2) @(negedge ACLK);
      ARESETn = 1'b1;
   endtask

   // One cycle: check last edge's outputs, drive new inputs, advance the model across the next edge.
   task automatic applyStimulus();
      logic [3:0] g;
      int         exp_g, p;
      bit         awv, awr, wv, wr, wl, bv, br;
      logic [LEN_W-1:0] len;
      @(negedge ACLK);
      g     = {m3_wgrnt, m2_wgrnt, m1_wgrnt, m0_wgrnt};
      exp_g = (m_owner >= 0) ? (1 << m_owner) : 0;
      checkOutput("grant", 32'(g), 32'(exp_g));
      checkOutput("w_en", 32'(w_en), 32'(m_phase == 2));
      checkOutput("b_en", 32'(b_en), 32'(m_phase == 3));
      checkOutput("busy", 32'(busy), 32'(m_owner >= 0));
`ifdef AXI_ARB_W_LEN_CHECK_EN
      checkOutput("len_err", 32'(len_err), 32'(m_err));
`else
      checkOutput("len_err", 32'(len_err), 32'h0);
`endif
      if (g != 4'b0000 && g != prev_g) order_q.push_back(ohIdx(g));
      prev_g = g;

      for (int i = 0; i < 4; i++) begin
         if (!pending[i] && $urandom_range(99) < req_pct) pending[i] = 1'b1;
      end
      if (hold_all) pending = 4'hF;
      len = (fixed_len >= 0) ? LEN_W'(fixed_len) : LEN_W'($urandom_range(3));
      awv = (m_phase == 1) && pending[m_owner];
      awr = $urandom_range(99) < aw_pct;
      wv  = (m_phase == 2) && ($urandom_range(99) < w_pct);
      wr  = (m_phase == 2) && ($urandom_range(99) < w_pct);
      wl  = (m_phase == 2) && (m_cnt == target_last);
      bv  = (m_phase == 3) && ($urandom_range(99) < b_pct);
      br  = (m_phase == 3) && ($urandom_range(99) < b_pct);

      {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID} = pending;
      s_AWVALID = awv; s_AWREADY = awr; s_AWLEN = len;
      s_WVALID = wv; s_WREADY = wr; s_WLAST = wl;
      s_BVALID = bv; s_BREADY = br;

      case (m_phase)
         0: begin
            p = pick(m_last, pending);
            if (p >= 0) begin m_owner = p; m_phase = 1; end
         end
         1: begin
            if (awv && awr) begin
               m_phase = 2; m_len = int'(len); m_cnt = 0;
               pending[m_owner] = hold_all;
               if (force_target >= 0) target_last = force_target;
               else if ($urandom_range(99) < bad_pct) target_last = $urandom_range(3);
               else target_last = m_len;
            end
         end
         2: begin
            if (wv && wr) begin
               if (wl != (m_cnt == m_len)) m_err = 1'b1;
               m_cnt++;
               if (wl) m_phase = 3;
            end
         end
         default: begin
            if (bv && br) begin
               m_last = m_owner;
               p = pick(m_last, pending);
               if (p >= 0) begin m_owner = p; m_phase = 1; end
               else begin m_owner = -1; m_phase = 0; end
            end
         end
      endcase
   endtask

   task automatic runUntil(input int phase, input int maxc);
      int c;
      c = 0;
      while (m_phase != phase && c < maxc) begin
         applyStimulus();
         c++;
      end
      checkOutput("reach_phase", 32'(m_phase), 32'(phase));
   endtask

   task automatic runUntilGrants(input int n, input int maxc);
      int c;
      c = 0;
      while (order_q.size() < n && c < maxc) begin
         applyStimulus();
         c++;
      end
      checkOutput("grant_count", 32'(order_q.size() >= n), 32'h1);
   endtask

   // Only the owner still in ADDR keeps its request, so it can finish its handshake.
   task automatic drain();
      hold_all = 1'b0;
      req_pct  = 0;
      pending  = 4'b0000;
      if (m_phase == 1) pending[m_owner] = 1'b1;
      aw_pct = 100; w_pct = 100; b_pct = 100;
      runUntil(0, 200);
   endtask

   initial begin
      req_pct = 0; aw_pct = 100; w_pct = 100; b_pct = 100;
      fixed_len = 3; bad_pct = 0; force_target = -1; target_last = 0;
      resetDut();

      // Lone m2 request: 4-beat burst, grant drops one cycle after B.
      pending = 4'b0100;
      runUntil(3, 50);
      runUntil(0, 50);
      checkOutput("m2_first", 32'(order_q.size() > 0 ? order_q[0] : -1), 32'd2);

      // All four requesting continuously: pure rotation from master 0.
      resetDut();
      fixed_len = 0; hold_all = 1'b1; pending = 4'hF;
      runUntilGrants(5, 100);
      for (int i = 0; i < 5 && i < order_q.size(); i++) begin
         checkOutput($sformatf("rr_order%0d", i), 32'(order_q[i]), 32'(i % 4));
      end
      drain();

      // m1 owns the bus; m0/m3 arrive mid-burst with W and B stalls.
      order_q.delete();
      fixed_len = 3; pending = 4'b0010; w_pct = 0;
      runUntil(2, 50);
      pending[0] = 1'b1; pending[3] = 1'b1;
      repeat (5) applyStimulus();
      w_pct = 100; b_pct = 0;
      runUntil(3, 50);
      repeat (3) applyStimulus();
      b_pct = 100;
      runUntilGrants(2, 50);
      checkOutput("m1_first", 32'(order_q.size() > 0 ? order_q[0] : -1), 32'd1);
      checkOutput("m3_next", 32'(order_q.size() > 1 ? order_q[1] : -1), 32'd3);
      pending = 4'b0001 | (m_phase == 1 ? (4'b0001 << m_owner) : 4'b0000);
      runUntil(0, 200);

      // Asynchronous reset mid-DATA, then master 0 wins a full contest.
      pending = 4'b0100; w_pct = 0;
      runUntil(2, 50);
      applyStimulus();
      @(posedge ACLK);
      #2;
      resetDut();
      w_pct = 100; fixed_len = 0; pending = 4'hF;
      runUntilGrants(1, 20);
      checkOutput("post_rst_m0", 32'(order_q.size() > 0 ? order_q[0] : -1), 32'd0);
      drain();

      // Short burst (WLAST on beat 3 of AWLEN=3) then a clean one; error must stay.
      resetDut();
      fixed_len = 3; force_target = 2; pending = 4'b0001;
      runUntil(3, 50);
      runUntil(0, 50);
      force_target = -1; pending = 4'b0010;
      runUntil(3, 50);
      runUntil(0, 50);
`ifdef AXI_ARB_W_LEN_CHECK_EN
      checkOutput("len_err_sticky", 32'(len_err), 32'h1);
`else
      checkOutput("len_err_sticky", 32'(len_err), 32'h0);
`endif
      resetDut();
      pending = 4'b0001;
      runUntil(3, 50);
      runUntil(0, 50);
      checkOutput("len_err_clean", 32'(len_err), 32'h0);

      // Random traffic with stalls and occasional wrong WLAST placement.
      resetDut();
      req_pct = 20; aw_pct = 60; w_pct = 60; b_pct = 60; fixed_len = -1; bad_pct = 10;
      repeat (2000) applyStimulus();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 500000);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/axi_arbiter_w.md
Name: axi_arbiter_w

Overview:
- Round-robin write-channel arbiter for four AXI masters sharing one slave port.
- Owns the AW/W/B arbitration in the subsystem interconnect; the matching read-channel arbiter handles AR/R.
- Grant is registered one-hot and held from AW handshake through the last W beat to B handshake, so write bursts never interleave.
- Also drives W-phase and B-phase enables that the interconnect mux uses to gate WVALID/WREADY and BVALID/BREADY.

Parameters:
- RESET_LAST, 3: index of the "last granted" master after reset; default gives master 0 first priority.
- LEN_W, 8: width of s_AWLEN; used only with the optional feature.

Ports:
- ACLK  in  1  system clock.
- ARESETn  in  1  reset; one clock, reset is asynchronous and active-low.
- m0_AWVALID..m3_AWVALID  in  1 each  raw write-address requests from masters 0..3.
- s_AWVALID  in  1  muxed AWVALID of the granted master.
- s_AWREADY  in  1  slave AWREADY.
- s_AWLEN  in  LEN_W  muxed AWLEN; used only with the optional feature.
- s_WVALID, s_WREADY, s_WLAST  in  1 each  muxed W handshake signals.
- s_BVALID, s_BREADY  in  1 each  slave BVALID and muxed BREADY.
- m0_wgrnt..m3_wgrnt  out  1 each  registered one-hot grant.
- w_en  out  1  high only in DATA; interconnect gates W valid/ready with it.
- b_en  out  1  high only in RESP; interconnect gates B valid/ready with it.
- busy  out  1  high whenever any grant is asserted.
- len_err  out  1  sticky burst-length error; optional feature only.

Behaviour:
- Reset (async assert, synchronous deassert at the board level):
  - state=IDLE, all grants 0, w_en=b_en=busy=0, last=RESET_LAST, len_err=0.
- States: IDLE, ADDR, DATA, RESP. Grants, w_en and b_en are flop outputs decoded from the state and grant registers.
- Arbitration function:
  - Search order is last+1, last+2, last+3, last, modulo 4.
  - First master with AWVALID=1 wins.
- IDLE:
  - If any mX_AWVALID, load the winner's grant and go to ADDR. Grant is visible the cycle after the request (1-cycle latency).
  - Otherwise stay; grants remain 0.
- ADDR:
  - Hold grant. On s_AWVALID&&s_AWREADY go to DATA.
  - If the granted master drops AWVALID before the handshake (protocol violation), the grant is still held; no re-arbitration.
- DATA:
  - w_en=1. On s_WVALID&&s_WREADY&&s_WLAST go to RESP.
  - Non-last beats keep the state unchanged.
- RESP:
  - b_en=1. On s_BVALID&&s_BREADY, set last=current grant index.
  - If the arbitration function (using the new last) finds a request, load the new grant and go to ADDR in the same edge. The back-to-back handover has no idle cycle.
  - Otherwise clear grants and go to IDLE.
- Requests arriving mid-transaction are ignored until the RESP exit; there is no preemption.
- Simultaneous requests are resolved only by rotating priority. Each master waits at most 3 other transactions.
- Async reset in any state returns to reset values immediately. The burst in flight is abandoned; the interconnect is reset together with the arbiter.
- W beats presented before DATA are not seen, because the interconnect gates them with w_en.

Optional Feature:
- Macro: AXI_ARB_W_LEN_CHECK_EN.
- Defined:
  - On the AW handshake, latch s_AWLEN into a LEN_W-bit register and clear a LEN_W+1-bit beat counter.
  - Each W handshake in DATA increments the counter.
  - If s_WLAST is seen with count!=latched_len, or count reaches latched_len without WLAST, set len_err=1. len_err stays set until reset.
  - The state flow is unaffected either way.
- Undefined: no length register or counter; len_err is tied to 0.

Test Plan:
- Reset, then m2_AWVALID=1 alone -> m2_wgrnt=1 one cycle later. Complete AW, 4 W beats with WLAST on beat 4, then B -> grant cleared one cycle after the B handshake, busy=0.
- All four AWVALID held high, each transaction 1 beat -> grant order 0,1,2,3,0. Handover directly from RESP to ADDR with no IDLE cycle between grants.
- m1 granted and in DATA; m0 and m3 raise AWVALID mid-burst -> m1 keeps the grant through WLAST and B. Next grant goes to m3 (after 1, order 2,3,0; 2 is idle).
- Assert ARESETn=0 asynchronously mid-DATA (between clock edges) -> all grants, w_en and b_en drop to 0 immediately. After release, m0 has priority.
- s_WREADY=0 for 5 cycles in DATA and s_BVALID delayed 3 cycles -> state and grant unchanged throughout. w_en=1 only in DATA, b_en=1 only in RESP.
- With AXI_ARB_W_LEN_CHECK_EN: AWLEN=3, WLAST on the 3rd beat -> len_err=1 and it stays 1 across later transactions. Repeat with WLAST on the 4th beat after reset -> len_err=0.
